hit_score_unit: RTL and testbench

//  Multi-fruit collision detector and score accumulator for the fruit game.

---
 rtl/hit_score_unit_if.sv | 32 +++
 rtl/hit_score_unit.sv | 137 +++++++++++++
 tb/tb_hit_score_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hit_score_unit_if.sv
// Port bundle for hit_score_unit: control/position inputs and hit/score outputs.
// The master drives positions and strobes; the slave (scorer) drives results.
interface hit_score_unit_if #(
    parameter int unsigned COORD_W    = 7,
    parameter int unsigned NUM_FRUITS = 4,
    parameter int unsigned SCORE_W    = 8
);
    logic                          clear;
    logic                          sample;
    logic [COORD_W-1:0]            char_x;
    logic [COORD_W-1:0]            char_y;
    logic [NUM_FRUITS*COORD_W-1:0] fruit_x;
    logic [NUM_FRUITS*COORD_W-1:0] fruit_y;
    logic [NUM_FRUITS*3-1:0]       fruit_colour;
    logic [NUM_FRUITS-1:0]         fruit_valid;
    logic                          hit_valid;
    logic [2:0]                    hit_idx;
    logic [2:0]                    hit_colour;
    logic [NUM_FRUITS-1:0]         hit_mask;
    logic [SCORE_W-1:0]            score;
    logic                          score_sat;

    modport master (
        output clear, sample, char_x, char_y, fruit_x, fruit_y, fruit_colour, fruit_valid,
        input  hit_valid, hit_idx, hit_colour, hit_mask, score, score_sat
    );

    modport slave (
        input  clear, sample, char_x, char_y, fruit_x, fruit_y, fruit_colour, fruit_valid,
        output hit_valid, hit_idx, hit_colour, hit_mask, score, score_sat
    );
endinterface

// File: rtl/hit_score_unit.sv
// Multi-fruit collision detector with rising-edge hit detection and a
// saturating score register; two-stage pipeline from sample to outputs.
module hit_score_unit #(
    parameter int unsigned COORD_W    = 7,
    parameter int unsigned NUM_FRUITS = 4,
    parameter int unsigned SCORE_W    = 8
) (
    input  logic             clk,
    input  logic             resetn,
    hit_score_unit_if.slave  bus
);
    localparam int unsigned DW = SCORE_W + 4;

    logic [NUM_FRUITS-1:0]   match;
    logic [NUM_FRUITS-1:0]   prev_q, prev_d;
    logic [NUM_FRUITS-1:0]   new_q, new_d;
    logic [NUM_FRUITS*3-1:0] col_q, col_d;
    logic                    hit_valid_q, hit_valid_d;
    logic [2:0]              hit_idx_q, hit_idx_d;
    logic [2:0]              hit_colour_q, hit_colour_d;
    logic [NUM_FRUITS-1:0]   hit_mask_q, hit_mask_d;
    logic [SCORE_W-1:0]      score_q, score_d;
    logic                    score_sat_q, score_sat_d;
    logic signed [DW-1:0]    delta;
    logic signed [DW:0]      sum;
    logic                    found;

    function automatic logic signed [DW-1:0] pts(input logic [2:0] c);
        case (c)
            3'd0:    pts = DW'(1);
            3'd1:    pts = DW'(2);
            3'd2:    pts = DW'(3);
            3'd3:    pts = DW'(4);
            3'd4:    pts = DW'(-1);
            3'd5:    pts = DW'(5);
            3'd6:    pts = DW'(-2);
            default: pts = '0;
        endcase
    endfunction

    // Stage 1: parallel compare, rising-edge detect against the last sampled match.
    always_comb begin
        match  = '0;
        prev_d = prev_q;
        new_d  = '0;
        col_d  = col_q;
        for (int unsigned i = 0; i < NUM_FRUITS; i++) begin
            match[i] = bus.fruit_valid[i]
                     && (bus.fruit_x[i*COORD_W +: COORD_W] == bus.char_x)
                     && (bus.fruit_y[i*COORD_W +: COORD_W] == bus.char_y)
                     && (bus.fruit_colour[i*3 +: 3] != 3'b111);
        end
        if (bus.clear) begin
            prev_d = '0;
        end else if (bus.sample) begin
            new_d  = match & ~prev_q;
            prev_d = match;
            col_d  = bus.fruit_colour;
        end
    end

    // Stage 2: report lowest new slot, accumulate points, clamp into score range.
    always_comb begin
        hit_valid_d  = 1'b0;
        hit_idx_d    = '0;
        hit_colour_d = '0;
        hit_mask_d   = '0;
        score_d      = score_q;
        score_sat_d  = score_sat_q;
        delta        = '0;
        found        = 1'b0;
        for (int unsigned i = 0; i < NUM_FRUITS; i++) begin
            if (new_q[i]) begin
                delta = delta + pts(col_q[i*3 +: 3]);
                if (!found) begin
                    found        = 1'b1;
                    hit_idx_d    = 3'(i);
                    hit_colour_d = col_q[i*3 +: 3];
                end
            end
        end
        sum = $signed({5'b0, score_q}) + $signed({delta[DW-1], delta});
        if (bus.clear) begin
            hit_idx_d    = '0;
            hit_colour_d = '0;
            score_d      = '0;
            score_sat_d  = 1'b0;
        end else if (|new_q) begin
            hit_valid_d = 1'b1;
            hit_mask_d  = new_q;
            if (sum < 0) begin
                score_d     = '0;
                score_sat_d = 1'b1;
            end else if (sum > $signed({5'b0, {SCORE_W{1'b1}}})) begin
                score_d     = '1;
                score_sat_d = 1'b1;
            end else begin
                score_d     = sum[SCORE_W-1:0];
                score_sat_d = 1'b0;
            end
        end else begin
            hit_idx_d    = '0;
            hit_colour_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_q       <= '0;
            new_q        <= '0;
            col_q        <= '0;
            hit_valid_q  <= 1'b0;
            hit_idx_q    <= '0;
            hit_colour_q <= '0;
            hit_mask_q   <= '0;
            score_q      <= '0;
            score_sat_q  <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            new_q        <= new_d;
            col_q        <= col_d;
            hit_valid_q  <= hit_valid_d;
            hit_idx_q    <= hit_idx_d;
            hit_colour_q <= hit_colour_d;
            hit_mask_q   <= hit_mask_d;
            score_q      <= score_d;
            score_sat_q  <= score_sat_d;
        end
    end

    assign bus.hit_valid  = hit_valid_q;
    assign bus.hit_idx    = hit_idx_q;
    assign bus.hit_colour = hit_colour_q;
    assign bus.hit_mask   = hit_mask_q;
    assign bus.score      = score_q;
    assign bus.score_sat  = score_sat_q;
endmodule

// File: tb/tb_hit_score_unit.sv
// Directed and randomized checks of hit_score_unit against a per-edge
// behavioural model of the scoring rules.
module tb_hit_score_unit;
    localparam int CW = 7;
    localparam int NF = 4;
    localparam int SW = 8;
    localparam int SMAX = (1 << SW) - 1;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    hit_score_unit_if #(.COORD_W(CW), .NUM_FRUITS(NF), .SCORE_W(SW)) bus ();

    hit_score_unit #(.COORD_W(CW), .NUM_FRUITS(NF), .SCORE_W(SW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int pts_tab [8] = '{1, 2, 3, 4, -1, 5, -2, 0};

    // model state
    int m_score;
    bit m_sat;
    bit m_prev [NF];
    int p_mask, p_idx, p_col, p_delta;
    int e_hv, e_mask, e_idx, e_col;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        m_score = 0; m_sat = 0;
        for (int i = 0; i < NF; i++) m_prev[i] = 0;
        p_mask = 0; p_idx = 0; p_col = 0; p_delta = 0;
        e_hv = 0; e_mask = 0; e_idx = 0; e_col = 0;
    endtask

    task automatic model_edge();
        int s;
        bit first;
        if (!resetn) begin
            reset_model();
        end else if (bus.clear) begin
            e_hv = 0; e_mask = 0; e_idx = 0; e_col = 0;
            m_score = 0; m_sat = 0;
            for (int i = 0; i < NF; i++) m_prev[i] = 0;
            p_mask = 0; p_idx = 0; p_col = 0; p_delta = 0;
        end else begin
            if (p_mask != 0) begin
                e_hv = 1; e_mask = p_mask; e_idx = p_idx; e_col = p_col;
                s = m_score + p_delta;
                if (s < 0)         begin m_score = 0;    m_sat = 1; end
                else if (s > SMAX) begin m_score = SMAX; m_sat = 1; end
                else               begin m_score = s;    m_sat = 0; end
            end else begin
                e_hv = 0; e_mask = 0; e_idx = 0; e_col = 0;
            end
            p_mask = 0; p_idx = 0; p_col = 0; p_delta = 0;
            if (bus.sample) begin
                first = 1;
                for (int i = 0; i < NF; i++) begin
                    int fx, fy, fc;
                    bit m;
                    fx = int'(bus.fruit_x[i*CW +: CW]);
                    fy = int'(bus.fruit_y[i*CW +: CW]);
                    fc = int'(bus.fruit_colour[i*3 +: 3]);
                    m = bus.fruit_valid[i] && fx == int'(bus.char_x) &&
                        fy == int'(bus.char_y) && fc != 7;
                    if (m && !m_prev[i]) begin
                        p_mask |= (1 << i);
                        p_delta += pts_tab[fc];
                        if (first) begin p_idx = i; p_col = fc; first = 0; end
                    end
                    m_prev[i] = m;
                end
            end
        end
    endtask

    task automatic check_outputs(input string ph);
        chk({ph, ".hit_valid"},  32'(bus.hit_valid),  32'(e_hv));
        chk({ph, ".hit_mask"},   32'(bus.hit_mask),   32'(e_mask));
        chk({ph, ".hit_idx"},    32'(bus.hit_idx),    32'(e_idx));
        chk({ph, ".hit_colour"}, 32'(bus.hit_colour), 32'(e_col));
        chk({ph, ".score"},      32'(bus.score),      32'(m_score));
        chk({ph, ".score_sat"},  32'(bus.score_sat),  32'(m_sat));
    endtask

    task automatic tick(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(ph);
        @(negedge clk);
    endtask

    task automatic set_slot(input int i, input int x, input int y, input int c, input bit v);
        bus.fruit_x[i*CW +: CW]  = CW'(x);
        bus.fruit_y[i*CW +: CW]  = CW'(y);
        bus.fruit_colour[i*3 +: 3] = 3'(c);
        bus.fruit_valid[i] = v;
    endtask

    task automatic set_char(input int x, input int y);
        bus.char_x = CW'(x);
        bus.char_y = CW'(y);
    endtask

    initial begin
        resetn = 1'b0;
        bus.clear = 0; bus.sample = 0;
        bus.char_x = '0; bus.char_y = '0;
        bus.fruit_x = '0; bus.fruit_y = '0; bus.fruit_colour = '0; bus.fruit_valid = '0;
        reset_model();
        @(negedge clk); @(negedge clk);
        check_outputs("reset");
        resetn = 1'b1;
        tick("idle");

        // single hit
        for (int i = 0; i < NF; i++) set_slot(i, 40 + i, 40, 0, 0);
        set_slot(0, 5, 9, 2, 1);
        set_char(5, 9);
        bus.sample = 1; tick("t2.s");
        bus.sample = 0; tick("t2.o");
        chk("t2.pulse", 32'(bus.hit_valid), 1);
        chk("t2.idx", 32'(bus.hit_idx), 0);
        chk("t2.colour", 32'(bus.hit_colour), 2);
        chk("t2.score", 32'(bus.score), 3);
        tick("t2.after");

        // persistent overlap scores once; leave and return scores again
        bus.sample = 1;
        for (int k = 0; k < 10; k++) tick("t3.hold");
        chk("t3.score_hold", 32'(bus.score), 3);
        set_char(6, 9); tick("t3.away");
        set_char(5, 9); tick("t3.back");
        bus.sample = 0; tick("t3.o");
        chk("t3.score_again", 32'(bus.score), 6);

        // multi hit with a black slot excluded
        set_slot(1, 20, 30, 5, 1);
        set_slot(2, 20, 30, 7, 1);
        set_slot(3, 20, 30, 0, 1);
        set_char(20, 30);
        bus.sample = 1; tick("t4.s");
        bus.sample = 0; tick("t4.o");
        chk("t4.mask", 32'(bus.hit_mask), 32'b1010);
        chk("t4.idx", 32'(bus.hit_idx), 1);
        chk("t4.colour", 32'(bus.hit_colour), 5);
        chk("t4.score", 32'(bus.score), 12);

        // saturation low
        bus.clear = 1; tick("t5.clr"); bus.clear = 0;
        for (int i = 0; i < NF; i++) set_slot(i, 60 + i, 60, 0, 0);
        set_slot(0, 1, 1, 0, 1);
        set_slot(1, 2, 2, 6, 1);
        bus.sample = 1;
        set_char(1, 1); tick("t5.a");
        set_char(2, 2); tick("t5.b");
        set_char(3, 3); tick("t5.c");
        chk("t5.score_low", 32'(bus.score), 0);
        chk("t5.sat_low", 32'(bus.score_sat), 1);

        // saturation high: 50 x 5 + 4 = 254, then +5 clamps at 255
        bus.clear = 1; tick("t5.clr2"); bus.clear = 0;
        set_slot(0, 1, 1, 5, 1);
        for (int k = 0; k < 50; k++) begin
            set_char(1, 1); tick("t5.up");
            set_char(3, 3); tick("t5.off");
        end
        set_slot(0, 1, 1, 3, 1);
        set_char(1, 1); tick("t5.up4");
        set_char(3, 3); tick("t5.off4");
        chk("t5.score254", 32'(bus.score), 254);
        chk("t5.sat254", 32'(bus.score_sat), 0);
        set_slot(0, 1, 1, 5, 1);
        set_char(1, 1); tick("t5.top");
        bus.sample = 0; tick("t5.topo");
        chk("t5.score_high", 32'(bus.score), 255);
        chk("t5.sat_high", 32'(bus.score_sat), 1);

        // clear collides with a due stage-2 hit
        set_char(3, 3); bus.sample = 1; tick("t6.off");
        set_char(1, 1); tick("t6.s");
        bus.sample = 0; bus.clear = 1; tick("t6.clr");
        bus.clear = 0;
        chk("t6.no_pulse", 32'(bus.hit_valid), 0);
        chk("t6.score", 32'(bus.score), 0);
        bus.sample = 1; tick("t6.resample");
        bus.sample = 0; tick("t6.o");
        chk("t6.anew", 32'(bus.score), 5);

        // clear in the same cycle as a sample drops that sample
        bus.sample = 1; bus.clear = 1; set_char(3, 3); tick("t6.cs_off");
        set_char(1, 1); tick("t6.cs");
        bus.clear = 0; bus.sample = 0; tick("t6.cs_o");
        tick("t6.cs_o2");

        // reset mid-pipeline
        set_char(3, 3); bus.sample = 1; tick("t1.off");
        set_char(1, 1); tick("t1.s");
        bus.sample = 0;
        resetn = 1'b0;
        #1;
        reset_model();
        check_outputs("t1.async");
        tick("t1.held");
        resetn = 1'b1;
        tick("t1.rel");
        chk("t1.no_pulse", 32'(bus.hit_valid), 0);
        chk("t1.score", 32'(bus.score), 0);
        tick("t1.rel2");

        // randomized traffic on a small grid so overlaps are frequent
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < NF; i++) begin
                if ($urandom_range(0, 3) == 0)
                    set_slot(i, $urandom_range(0, 2), $urandom_range(0, 2),
                             $urandom_range(0, 7), 1'($urandom_range(0, 4) != 0));
            end
            set_char($urandom_range(0, 2), $urandom_range(0, 2));
            bus.sample = ($urandom_range(0, 3) != 0);
            bus.clear  = ($urandom_range(0, 40) == 0);
            tick("rand");
        end
        bus.clear = 0; bus.sample = 0;
        tick("drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
